// File: rtl/mario_input_pkg.sv
// mario_input_pkg: scan codes, key flag indices and switch byte bit positions
// shared by the Mario cabinet input conditioning stage.
package mario_input_pkg;
    localparam int NKEYS = 15;
    localparam int K_L = 0, K_R = 1, K_SPACE = 2, K_CTRL = 3, K_F1 = 4, K_F2 = 5, K_1 = 6, K_2 = 7;
    localparam int K_5 = 8, K_6 = 9, K_D = 10, K_G = 11, K_A = 12, K_T = 13, K_P = 14;
    localparam logic [8:0] SC_L = 9'h06B, SC_R = 9'h074, SC_SPACE = 9'h029, SC_CTRL = 9'h014;
    localparam logic [8:0] SC_F1 = 9'h005, SC_F2 = 9'h006, SC_1 = 9'h016, SC_2 = 9'h01E;
    localparam logic [8:0] SC_5 = 9'h02E, SC_6 = 9'h036, SC_D = 9'h023, SC_G = 9'h034;
    localparam logic [8:0] SC_A = 9'h01C, SC_T = 9'h02C, SC_P = 9'h04D;
    localparam logic [8:0] KEY_CODE [NKEYS] = '{SC_L, SC_R, SC_SPACE, SC_CTRL, SC_F1, SC_F2,
        SC_1, SC_2, SC_5, SC_6, SC_D, SC_G, SC_A, SC_T, SC_P};
    localparam int SW_RIGHT = 0, SW_LEFT = 1, SW_FIRE = 4;
    localparam int SW1_START1 = 5, SW1_START2 = 6, SW1_TEST = 7, SW2_COIN = 5;
    localparam logic [7:0] SW_IDLE = 8'hFF;
endpackage

// File: rtl/mario_input_ctrl_dir2_resolve.sv
// dir2_resolve: last-pressed-wins resolver for a {left,right} pair; when both
// are held the most recently pressed direction is reported.
module dir2_resolve
    import mario_input_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] din,
    output logic [1:0] dout
);
    logic [1:0] in1_q, in2_q, last_q, dout_q;
    logic [1:0] rise, last_d, dout_d;

    // Resolve against the updated last_dir so a fresh press wins in the same cycle
    always_comb begin
        rise   = in1_q & ~in2_q;
        last_d = rise[1] ? 2'b10 : rise[0] ? 2'b01 : last_q;
        dout_d = (in1_q == 2'b11) ? last_d : in1_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            in1_q  <= '0;
            in2_q  <= '0;
            last_q <= '0;
            dout_q <= '0;
        end else begin
            in1_q  <= din;
            in2_q  <= in1_q;
            last_q <= last_d;
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
endmodule

// File: rtl/mario_input_ctrl.sv
// mario_input_ctrl: turns ps2 key events and joysticks into active-low cabinet
// switch bytes, stretches coin pulses and runs the pause/dim controller.
module mario_input_ctrl
    import mario_input_pkg::*;
#(
    parameter logic [31:0] DIM_CYCLES  = 32'h1C9C3800,
    parameter int          COIN_CYCLES = 2_400_000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy_0,
    input  logic [15:0] joy_1,
    input  logic        osd_status,
    input  logic        osd_pause_en,
    input  logic        hs_access,
    output logic [7:0]  sw1,
    output logic [7:0]  sw2,
    output logic        pause,
    output logic        dim_video
);
    logic             old_toggle_q, ev;
    logic [NKEYS-1:0] keys_q, keys_d;
    logic [1:0]       dir1_in, dir2_in, dir1, dir2;
    logic             req, req_q, coin;
    logic [31:0]      cnt_q, cnt_d, timer_q, timer_d;
    logic             pin, pin_q, toggle_q, toggle_d, pause_c, pause_q, dim_q;
    logic             fire, fire2, start1, start2;
    logic [7:0]       sw1_q, sw1_d, sw2_q, sw2_d;
    logic             unused_joy;

    assign unused_joy = ^{joy_0[15:9], joy_0[3:2], joy_1[15:9], joy_1[6], joy_1[3:2]};

    // Direction codes match on the low byte only, so extended variants count too
    always_comb begin
        ev     = ps2_key[10] != old_toggle_q;
        keys_d = keys_q;
        for (int k = 0; k < NKEYS; k++)
            if (ev && ((k == K_L || k == K_R) ? ps2_key[7:0] == KEY_CODE[k][7:0]
                                              : ps2_key[8:0] == KEY_CODE[k]))
                keys_d[k] = ps2_key[9];
    end

    assign dir1_in = {keys_q[K_L] | joy_0[1], keys_q[K_R] | joy_0[0]};
    assign dir2_in = {keys_q[K_D] | joy_1[1], keys_q[K_G] | joy_1[0]};

    dir2_resolve u_dir1 (.clk_sys(clk_sys), .reset(reset), .din(dir1_in), .dout(dir1));
    dir2_resolve u_dir2 (.clk_sys(clk_sys), .reset(reset), .din(dir2_in), .dout(dir2));

    always_comb begin
        req      = joy_0[7] | joy_1[7] | keys_q[K_5] | keys_q[K_6];
        cnt_d    = (req && !req_q) ? 32'(COIN_CYCLES - 1) : (cnt_q != '0) ? cnt_q - 32'd1 : cnt_q;
        coin     = req | (cnt_q != '0);
        pin      = joy_0[8] | joy_1[8] | keys_q[K_P];
        toggle_d = toggle_q ^ (pin & ~pin_q);
        pause_c  = hs_access | toggle_d | (osd_status & osd_pause_en);
        timer_d  = !pause_c ? '0 : (timer_q >= DIM_CYCLES) ? timer_q : timer_q + 32'd1;
        fire     = keys_q[K_SPACE] | keys_q[K_CTRL] | joy_0[4];
        fire2    = keys_q[K_A] | joy_1[4];
        start1   = joy_0[5] | keys_q[K_F1] | keys_q[K_1];
        start2   = joy_0[6] | joy_1[5] | keys_q[K_F2] | keys_q[K_2];
        sw1_d    = SW_IDLE;
        sw1_d[SW_RIGHT]   = ~dir1[0];
        sw1_d[SW_LEFT]    = ~dir1[1];
        sw1_d[SW_FIRE]    = ~fire;
        sw1_d[SW1_START1] = ~start1;
        sw1_d[SW1_START2] = ~start2;
        sw1_d[SW1_TEST]   = ~keys_q[K_T];
        sw2_d    = SW_IDLE;
        sw2_d[SW_RIGHT]   = ~dir2[0];
        sw2_d[SW_LEFT]    = ~dir2[1];
        sw2_d[SW_FIRE]    = ~fire2;
        sw2_d[SW2_COIN]   = ~coin;
    end

    always_ff @(posedge clk_sys) begin
        old_toggle_q <= ps2_key[10];
        if (reset) begin
            keys_q   <= '0;
            req_q    <= 1'b0;
            cnt_q    <= '0;
            pin_q    <= 1'b0;
            toggle_q <= 1'b0;
            timer_q  <= '0;
            pause_q  <= 1'b0;
            dim_q    <= 1'b0;
            sw1_q    <= SW_IDLE;
            sw2_q    <= SW_IDLE;
        end else begin
            keys_q   <= keys_d;
            req_q    <= req;
            cnt_q    <= cnt_d;
            pin_q    <= pin;
            toggle_q <= toggle_d;
            timer_q  <= timer_d;
            pause_q  <= pause_c;
            dim_q    <= timer_q >= DIM_CYCLES;
            sw1_q    <= sw1_d;
            sw2_q    <= sw2_d;
        end
    end

    assign sw1       = sw1_q;
    assign sw2       = sw2_q;
    assign pause     = pause_q;
    assign dim_video = dim_q;
endmodule

// File: tb/tb_mario_input_ctrl.sv
// tb_mario_input_ctrl: directed stimulus queues timed expectations; a negedge
// monitor compares every entry whose cycle has arrived.
module tb_mario_input_ctrl;
    logic        clk = 1'b0;
    logic        reset, osd_status, osd_pause_en, hs_access;
    logic [10:0] ps2_key;
    logic [15:0] joy_0, joy_1;
    logic [7:0]  sw1, sw2;
    logic        pause, dim_video;

    typedef struct {
        int         at;
        int         sel;
        logic [7:0] mask;
        logic [7:0] exp;
        string      name;
    } chk_t;

    chk_t q[$];
    int   cyc = 0, total = 0, bad = 0;
    logic stuck = 1'b0;

    mario_input_ctrl #(.DIM_CYCLES(32'd16), .COIN_CYCLES(8)) dut (
        .clk_sys(clk), .reset(reset), .ps2_key(ps2_key), .joy_0(joy_0), .joy_1(joy_1),
        .osd_status(osd_status), .osd_pause_en(osd_pause_en), .hs_access(hs_access),
        .sw1(sw1), .sw2(sw2), .pause(pause), .dim_video(dim_video));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        logic [7:0] act;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at <= cyc) begin
                act = q[i].sel == 0 ? sw1 : q[i].sel == 1 ? sw2 : q[i].sel == 2 ? {7'd0, pause} : {7'd0, dim_video};
                total++;
                if (q[i].at != cyc || (act & q[i].mask) != (q[i].exp & q[i].mask)) begin
                    bad++;
                    $display("FAIL %s @cyc %0d: got %h want %h (mask %h)", q[i].name, cyc, act, q[i].exp, q[i].mask);
                end
                q.delete(i);
            end
        end
        if (stuck && q.size() != 0) begin
            bad += q.size();
            $display("FAIL drain: %0d expectations never reached, want 0", q.size());
            q.delete();
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input int dt, input int sel, input logic [7:0] mask, input logic [7:0] exp, input string name);
        chk_t c;
        c.at = cyc + dt; c.sel = sel; c.mask = mask; c.exp = exp; c.name = name;
        q.push_back(c);
    endtask

    task automatic key(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    task automatic idle_all(input int dt, input string name);
        chk(dt, 0, 8'hFF, 8'hFF, {name, "_sw1"});
        chk(dt, 1, 8'hFF, 8'hFF, {name, "_sw2"});
        chk(dt, 2, 8'h01, 8'h00, {name, "_pause"});
        chk(dt, 3, 8'h01, 8'h00, {name, "_dim"});
    endtask

    initial begin
        reset = 1; ps2_key = '0; joy_0 = '0; joy_1 = '0;
        osd_status = 0; osd_pause_en = 0; hs_access = 0;
        tick(2);
        idle_all(0, "rst");
        reset = 0;
        idle_all(1, "idle1");
        idle_all(10, "idle10");
        tick(12);
        // directions: L, then R while L held, then release both
        key(1, 9'h06B); chk(3, 0, 8'h03, 8'h03, "L_early"); chk(4, 0, 8'h03, 8'h01, "L");
        tick(20);
        key(1, 9'h074); chk(3, 0, 8'h03, 8'h01, "both_old"); chk(4, 0, 8'h03, 8'h02, "both_R");
        chk(15, 0, 8'h03, 8'h02, "both_hold");
        tick(20);
        key(0, 9'h06B); chk(4, 0, 8'h03, 8'h02, "L_rel");
        tick(10);
        key(0, 9'h174); chk(4, 0, 8'h03, 8'h03, "R_rel_ext");
        tick(10);
        joy_1[1] = 1; chk(2, 1, 8'h03, 8'h03, "p2L_early"); chk(3, 1, 8'h03, 8'h01, "p2L");
        tick(5); joy_1[1] = 0; tick(10);
        key(1, 9'h0FF); chk(3, 0, 8'hFF, 8'hFF, "unlisted_sw1"); chk(3, 1, 8'hFF, 8'hFF, "unlisted_sw2");
        tick(5); key(0, 9'h0FF); tick(5);
        key(1, 9'h029); chk(1, 0, 8'hFF, 8'hFF, "fire_early"); chk(2, 0, 8'hFF, 8'hEF, "fire");
        tick(5); key(0, 9'h029); chk(2, 0, 8'hFF, 8'hFF, "fire_rel"); tick(5);
        key(1, 9'h02C); chk(2, 0, 8'hFF, 8'h7F, "test");
        tick(5); key(0, 9'h02C); tick(5);
        joy_1[5] = 1; chk(1, 0, 8'hFF, 8'hBF, "p2_start2");
        tick(3); joy_1[5] = 0; tick(3);
        key(1, 9'h01C); chk(2, 1, 8'hFF, 8'hEF, "fire2");
        tick(5); key(0, 9'h01C); tick(5);
        // coin stretch: single pulse, re-triggered pulse, held key
        joy_0[7] = 1;
        chk(0, 1, 8'h20, 8'h20, "coin_pre"); chk(1, 1, 8'h20, 8'h00, "coin_start");
        chk(8, 1, 8'h20, 8'h00, "coin_last"); chk(9, 1, 8'h20, 8'h20, "coin_end");
        tick(1); joy_0[7] = 0; tick(20);
        joy_0[7] = 1;
        chk(1, 1, 8'h20, 8'h00, "coin2_start"); chk(12, 1, 8'h20, 8'h00, "coin2_last");
        chk(13, 1, 8'h20, 8'h20, "coin2_end");
        tick(1); joy_0[7] = 0; tick(3);
        joy_0[7] = 1; tick(1); joy_0[7] = 0; tick(20);
        key(1, 9'h02E); chk(1, 1, 8'h20, 8'h20, "key5_early"); chk(2, 1, 8'h20, 8'h00, "key5");
        tick(20);
        key(0, 9'h02E); chk(1, 1, 8'h20, 8'h00, "key5_held"); chk(2, 1, 8'h20, 8'h20, "key5_rel");
        tick(10);
        // pause toggle and dim
        joy_1[8] = 1;
        chk(0, 2, 8'h01, 8'h00, "pause_pre"); chk(1, 2, 8'h01, 8'h01, "pause_on");
        chk(16, 3, 8'h01, 8'h00, "dim_early"); chk(17, 3, 8'h01, 8'h01, "dim_on");
        chk(60, 2, 8'h01, 8'h01, "pause_hold");
        tick(100); joy_1[8] = 0;
        chk(3, 2, 8'h01, 8'h01, "pause_after_rel"); chk(3, 3, 8'h01, 8'h01, "dim_after_rel");
        tick(5); joy_1[8] = 1;
        chk(1, 2, 8'h01, 8'h00, "pause_off"); chk(2, 3, 8'h01, 8'h00, "dim_off");
        tick(3); joy_1[8] = 0; tick(5);
        osd_status = 1; osd_pause_en = 1; chk(1, 2, 8'h01, 8'h01, "osd_pause");
        tick(3); osd_pause_en = 0; chk(1, 2, 8'h01, 8'h00, "osd_nopause");
        tick(3); hs_access = 1; chk(1, 2, 8'h01, 8'h01, "hs_osd");
        tick(2); osd_status = 0; chk(1, 2, 8'h01, 8'h01, "hs_only");
        tick(2); hs_access = 0; chk(1, 2, 8'h01, 8'h00, "hs_off");
        tick(5);
        // reset mid coin pulse
        joy_0[7] = 1; tick(1); joy_0[7] = 0; tick(2);
        chk(0, 1, 8'h20, 8'h00, "coin_before_rst");
        reset = 1; chk(1, 1, 8'hFF, 8'hFF, "coin_rst");
        tick(1); reset = 0;
        chk(1, 1, 8'hFF, 8'hFF, "coin_rst_after"); chk(5, 1, 8'hFF, 8'hFF, "coin_rst_late");
        tick(6);
        // reset while paused, dimmed and with a key held
        joy_1[8] = 1; tick(1); joy_1[8] = 0; tick(20);
        key(1, 9'h029);
        if (ps2_key[10] == 1'b0) key(1, 9'h029);
        tick(3);
        chk(0, 2, 8'h01, 8'h01, "pd_pause"); chk(0, 3, 8'h01, 8'h01, "pd_dim"); chk(0, 0, 8'hFF, 8'hEF, "pd_fire");
        reset = 1; idle_all(1, "pd_rst");
        tick(1); reset = 0;
        idle_all(1, "pd_rel1"); idle_all(4, "pd_rel4");
        tick(8);
        for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
        stuck = 1'b1;
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
